xbar_eject_port: RTL and testbench
==================================

// Module: xbar_eject_port
// PURPOSE
//  Node-side ejection endpoint for the crossbar. One instance per node.
//  Captures the one-cycle packet pulse the crossbar delivers to this node.
//  Buffers packets in a circular queue and hands them to the core over a valid/ready handshake.
//  Flags misrouted packets and overflow; no backpressure path exists, so almost_full is advisory.
// PARAMETERS
//  NODE_ID      0  node index this port serves; compared with pkt.dest
//  DEPTH        8  queue entries; power of 2, >=2
//  AFULL_THRESH 2  almost_full asserts when free entries <= AFULL_THRESH
// PORTS
//  clk           in   1               clock
//  reset         in   1               synchronous, active-high
//  rx_valid      in   1               crossbar delivered a packet this cycle (single-cycle pulse)
//  rx_pkt        in   $bits(pkt_t)    delivered packet, valid with rx_valid
//  out_valid     out  1               queue head valid to core
//  out_pkt       out  $bits(pkt_t)    queue head packet
//  out_ready     in   1               core accepts head this cycle
//  count         out  $clog2(DEPTH)+1 occupied entries
//  almost_full   out  1               free entries <= AFULL_THRESH
//  misroute_err  out  1               sticky: a packet with dest != NODE_ID was seen
//  overflow_err  out  1               sticky: a packet was dropped because the queue was full
//  stat_rx_cnt   out  NUMNODES x 16   per-source accepted-packet counters (see CONFIGURATION)
//  stat_drop_cnt out  16              dropped-packet counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: one clk with reset=1 clears pointers, count=0, out_valid=0, out_pkt=0, both sticky errors, all stats.
//    Reset mid-operation discards queued packets; rx_valid is ignored in the reset cycle.
//  - pop = out_valid & out_ready.
//  - push = rx_valid & (rx_pkt.dest == NODE_ID) & (count < DEPTH | pop).
//  - Head is first-word-fall-through: rx_valid in cycle N with the queue empty gives out_valid=1
//    and out_pkt=rx_pkt in cycle N+1. No same-cycle bypass.
//  - Full queue with simultaneous push and pop: both happen, count is unchanged, no drop.
//  - Full queue with push attempted and no pop: packet dropped, overflow_err set, count unchanged.
//  - dest != NODE_ID: packet dropped, misroute_err set; this takes precedence over the overflow check.
//  - Empty queue with pop: impossible, because out_valid=0.
//  - Empty queue with push: count goes to 1.
//  - Pointers wrap mod DEPTH.
//  - count := count + push - pop; it never exceeds DEPTH and never goes below 0.
//  - out_pkt holds its value while out_valid=1 and out_ready=0; packets leave in arrival order.
//  - almost_full is combinational from count; sticky errors clear only on reset.
// CONFIGURATION
//  XBAR_EJECT_STATS_EN defined:
//   - stat_rx_cnt[pkt.src] increments on every push, saturating at 16'hFFFF.
//   - stat_drop_cnt increments on every misroute or overflow drop, saturating at 16'hFFFF.
//  XBAR_EJECT_STATS_EN undefined: ports still exist, tied to 0, and no counter flops are built.
// STRUCTURE
//  - NetworkPkg holds pkt_t (src[7:0], dest[7:0], payload) and NUMNODES; no local redefinition.
//  - Sub-module xbar_eject_fifo: circular buffer, params WIDTH/DEPTH, same-cycle push+pop when full.
//    It exports count and head.
//  - The top level holds the accept/drop decision, the sticky flags and the stats.
// TESTING
//  1 Reset: hold reset 1 cycle -> count=0, out_valid=0, errors=0, stats=0.
//  2 Latency: NODE_ID=3, rx pkt{src=1,dest=3} in cycle 5, out_ready=1
//    -> out_valid=1 in cycle 6 with the same packet, count back to 0 in cycle 7.
//  3 Fill/overflow: out_ready=0, 9 pulses, DEPTH=8
//    -> count=8, almost_full from the 6th push, 9th dropped, overflow_err=1, stat_drop_cnt=1 (STATS_EN).
//  4 Full with push+pop: full queue, rx_valid=1 and out_ready=1 same cycle
//    -> count stays 8, no drop, order preserved over 16 pops.
//  5 Misroute: pkt dest=2 into NODE_ID=3 -> count unchanged, misroute_err=1, stays 1 until reset.
//  6 Stats: 3 packets src=0 and 2 packets src=4 -> stat_rx_cnt[0]=3, [4]=2.
//    Without the macro all stats read 0. Also force 16'hFFFF and confirm saturation.

Source files
------------

// File: rtl/xbar_eject_port_pkg.sv
// Shared crossbar packet types and field accessors.
// Used by the ejection port and its queue.
package NetworkPkg;

  localparam int NUMNODES  = 8;
  localparam int PAYLOAD_W = 16;

  typedef struct packed {
    logic [7:0]           src;
    logic [7:0]           dest;
    logic [PAYLOAD_W-1:0] payload;
  } pkt_t;

  localparam int PKT_W = $bits(pkt_t);

  function automatic logic [7:0] pkt_dest(
    input logic [PKT_W-1:0] p
  );
    pkt_t t;
    t = p;
    return t.dest;
  endfunction

  function automatic logic [7:0] pkt_src(
    input logic [PKT_W-1:0] p
  );
    pkt_t t;
    t = p;
    return t.src;
  endfunction

endpackage

// File: rtl/xbar_eject_fifo.sv
// Circular packet queue with first-word-fall-through head.
// A push and a pop in the same cycle are legal even when full.
module xbar_eject_fifo
  import NetworkPkg::*;
#(
  parameter int WIDTH = PKT_W,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/xbar_eject_port.sv
// Crossbar ejection endpoint: accept/drop decision, queue, sticky errors.
// Define XBAR_EJECT_STATS_EN to build the per-source and drop counters.
module xbar_eject_port
  import NetworkPkg::*;
#(
  parameter int NODE_ID      = 0,
  parameter int DEPTH        = 8,
  parameter int AFULL_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx_valid,
  input  logic [PKT_W-1:0]       rx_pkt,
  output logic                   out_valid,
  output logic [PKT_W-1:0]       out_pkt,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full,
  output logic                   misroute_err,
  output logic                   overflow_err,
  output logic [NUMNODES*16-1:0] stat_rx_cnt,
  output logic [15:0]            stat_drop_cnt
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic          dest_ok;
  logic          room;
  logic          pop;
  logic          push;
  logic          mis_drop;
  logic          ovf_drop;
  logic [CW-1:0] free;

  assign dest_ok  = pkt_dest(rx_pkt) == 8'(NODE_ID);
  assign pop      = out_valid & out_ready;
  assign room     = (count < DEPTH_C) | pop;
  assign push     = rx_valid & dest_ok & room;
  // Misroute wins over overflow: a wrong-dest packet never counts as overflow.
  assign mis_drop = rx_valid & ~dest_ok;
  assign ovf_drop = rx_valid & dest_ok & ~room;

  xbar_eject_fifo #(
    .WIDTH (PKT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (rx_pkt),
    .head  (out_pkt),
    .count (count)
  );

  assign out_valid   = count != '0;
  assign free        = DEPTH_C - count;
  assign almost_full = int'(free) <= AFULL_THRESH;

  always_ff @(posedge clk) begin
    if (reset) begin
      misroute_err <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      if (mis_drop) misroute_err <= 1'b1;
      if (ovf_drop) overflow_err <= 1'b1;
    end
  end

`ifdef XBAR_EJECT_STATS_EN
  logic [15:0] rx_cnt_q [NUMNODES];
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUMNODES; i++) rx_cnt_q[i] <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUMNODES; i++) begin
        if (push && pkt_src(rx_pkt) == 8'(i) && rx_cnt_q[i] != 16'hFFFF)
          rx_cnt_q[i] <= rx_cnt_q[i] + 16'd1;
      end
      if ((mis_drop | ovf_drop) && drop_cnt_q != 16'hFFFF)
        drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  for (genvar g = 0; g < NUMNODES; g++) begin : g_stat
    assign stat_rx_cnt[g*16 +: 16] = rx_cnt_q[g];
  end
  assign stat_drop_cnt = drop_cnt_q;
`else
  assign stat_rx_cnt   = '0;
  assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_xbar_eject_port.sv
// Directed bench for xbar_eject_port with a queue-based reference model.
// Honours XBAR_EJECT_STATS_EN when expecting counter values.
module tb_xbar_eject_port;
  import NetworkPkg::*;

  localparam int NODE  = 3;
  localparam int DEPTH = 8;
  localparam int AF    = 2;
`ifdef XBAR_EJECT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   rx_valid;
  pkt_t                   rx_pkt;
  logic                   out_valid;
  pkt_t                   out_pkt;
  logic                   out_ready;
  logic [3:0]             count;
  logic                   almost_full;
  logic                   misroute_err;
  logic                   overflow_err;
  logic [NUMNODES*16-1:0] stat_rx_cnt;
  logic [15:0]            stat_drop_cnt;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  pkt_t q[$];
  bit   m_mis;
  bit   m_ovf;
  int   m_rx [NUMNODES];
  int   m_drop;

  xbar_eject_port #(
    .NODE_ID      (NODE),
    .DEPTH        (DEPTH),
    .AFULL_THRESH (AF)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .rx_valid      (rx_valid),
    .rx_pkt        (rx_pkt),
    .out_valid     (out_valid),
    .out_pkt       (out_pkt),
    .out_ready     (out_ready),
    .count         (count),
    .almost_full   (almost_full),
    .misroute_err  (misroute_err),
    .overflow_err  (overflow_err),
    .stat_rx_cnt   (stat_rx_cnt),
    .stat_drop_cnt (stat_drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue plus counters, advanced on each rising edge.
  always @(posedge clk) begin : model
    bit pop;
    bit push;
    if (reset) begin
      q.delete();
      m_mis  = 1'b0;
      m_ovf  = 1'b0;
      m_drop = 0;
      for (int i = 0; i < NUMNODES; i++) m_rx[i] = 0;
    end else begin
      pop  = (q.size() != 0) && out_ready;
      push = 1'b0;
      if (rx_valid) begin
        if (int'(rx_pkt.dest) != NODE) begin
          m_mis = 1'b1;
          if (m_drop < 65535) m_drop++;
        end else if (q.size() < DEPTH || pop) begin
          push = 1'b1;
        end else begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
      end
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(rx_pkt);
        if (int'(rx_pkt.src) < NUMNODES && m_rx[rx_pkt.src] < 65535)
          m_rx[rx_pkt.src]++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("count", count, q.size());
      chk("out_valid", out_valid, q.size() != 0);
      chk("out_pkt", out_pkt, (q.size() != 0) ? q[0] : pkt_t'(0));
      chk("almost_full", almost_full, (DEPTH - q.size()) <= AF);
      chk("misroute_err", misroute_err, m_mis);
      chk("overflow_err", overflow_err, m_ovf);
      chk("stat_drop", stat_drop_cnt, STATS ? m_drop : 0);
      for (int i = 0; i < NUMNODES; i++)
        chk("stat_rx", stat_rx_cnt[i*16 +: 16], STATS ? m_rx[i] : 0);
    end
  end

  task automatic step(input bit v, input logic [7:0] s, input logic [7:0] d,
                      input logic [15:0] p, input bit rdy);
    rx_valid       = v;
    rx_pkt.src     = s;
    rx_pkt.dest    = d;
    rx_pkt.payload = p;
    out_ready      = rdy;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  int cnt_exp [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 8};
  bit af_exp  [9] = '{0, 0, 0, 0, 0, 1, 1, 1, 1};

  initial begin
    // Reset cycle with a pulse that must be ignored
    reset     = 1'b1;
    rx_valid  = 1'b1;
    rx_pkt    = '{src: 8'd1, dest: 8'd3, payload: 16'h0055};
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    rx_valid = 1'b0;
    cmp_en   = 1'b1;
    chk("rst_count", count, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pkt", out_pkt, 0);
    chk("rst_errs", {misroute_err, overflow_err}, 0);
    chk("rst_stats", {stat_rx_cnt, stat_drop_cnt}, 0);

    // Latency: head visible the cycle after the pulse
    step(1, 8'd1, 8'd3, 16'hA001, 1);
    chk("lat_valid", out_valid, 1);
    chk("lat_pkt", out_pkt, 32'h0103_A001);
    step(0, 8'd0, 8'd0, 16'h0, 1);
    chk("lat_drain", count, 0);

    // Fill then overflow
    for (int k = 0; k < 9; k++) begin
      step(1, 8'd2, 8'd3, 16'(16'h101 + k), 0);
      chk("fill_count", count, cnt_exp[k]);
      chk("fill_af", almost_full, af_exp[k]);
    end
    chk("ovf_err", overflow_err, 1);
    chk("ovf_drop", stat_drop_cnt, STATS ? 1 : 0);
    chk("ovf_head", out_pkt.payload, 16'h0101);

    // Full with simultaneous push and pop
    for (int k = 0; k < 8; k++) begin
      step(1, 8'd2, 8'd3, 16'(16'h201 + k), 1);
      chk("full_pp_count", count, 8);
    end
    chk("full_pp_drop", stat_drop_cnt, STATS ? 1 : 0);
    chk("full_pp_head", out_pkt.payload, 16'h0201);
    for (int k = 0; k < 8; k++) step(0, 8'd0, 8'd0, 16'h0, 1);
    chk("drain16", count, 0);

    // Misroute is sticky
    step(1, 8'd5, 8'd2, 16'h0BAD, 0);
    chk("mis_count", count, 0);
    chk("mis_err", misroute_err, 1);
    for (int k = 0; k < 3; k++) step(0, 8'd0, 8'd0, 16'h0, 0);
    chk("mis_sticky", misroute_err, 1);

    // Reset mid-operation discards queued packets
    step(1, 8'd0, 8'd3, 16'h0301, 0);
    step(1, 8'd0, 8'd3, 16'h0302, 0);
    reset = 1'b1;
    step(1, 8'd0, 8'd3, 16'h0303, 0);
    reset = 1'b0;
    chk("mid_rst_count", count, 0);
    chk("mid_rst_pkt", out_pkt, 0);
    chk("mid_rst_mis", misroute_err, 0);

    // Misroute into a full queue is not an overflow
    for (int k = 0; k < 8; k++) step(1, 8'd6, 8'd3, 16'(16'h401 + k), 0);
    step(1, 8'd6, 8'd7, 16'h04FF, 0);
    chk("prec_ovf", overflow_err, 0);
    chk("prec_mis", misroute_err, 1);
    chk("prec_count", count, 8);

    // Per-source statistics
    reset = 1'b1;
    step(0, 8'd0, 8'd0, 16'h0, 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) step(1, 8'd0, 8'd3, 16'(16'h500 + k), 0);
    for (int k = 0; k < 2; k++) step(1, 8'd4, 8'd3, 16'(16'h600 + k), 0);
    chk("stat_src0", stat_rx_cnt[0 +: 16], STATS ? 3 : 0);
    chk("stat_src4", stat_rx_cnt[64 +: 16], STATS ? 2 : 0);

`ifdef XBAR_EJECT_STATS_EN
    // Drop counter saturates at all-ones
    force dut.drop_cnt_q = 16'hFFFF;
    m_drop = 65535;
    step(0, 8'd0, 8'd0, 16'h0, 0);
    release dut.drop_cnt_q;
    step(1, 8'd1, 8'd0, 16'h0700, 0);
    step(1, 8'd1, 8'd0, 16'h0701, 0);
    chk("sat_drop", stat_drop_cnt, 16'hFFFF);
`endif

    for (int k = 0; k < 6; k++) step(0, 8'd0, 8'd0, 16'h0, 1);
    chk("final_count", count, 0);
    cmp_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
